// File: rtl/key_expansion_multi.sv
// AES key schedule for 128/192/256-bit keys, one word per cycle into a word store with an indexed round-key read port.
// Optional chained start (seed from the previous schedule's tail) is enabled by defining KEYEXP_CHAIN_EN.

module key_expansion_sbox (
    input  logic [7:0] i_In,
    output logic [7:0] o_Out
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // entry x sits at bits [8*(255-x)+7 -: 8], i.e. {~x,3'b111}
    assign o_Out = SBOX[{~i_In, 3'b111} -: 8];
endmodule

module key_expansion_multi #(
    parameter int MAX_KEY_BITS = 256
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [MAX_KEY_BITS-1:0] i_Key,
    input  logic [1:0]              i_Mode,
    input  logic                    i_fStart,
`ifdef KEYEXP_CHAIN_EN
    input  logic                    i_fIsFirst,
`endif
    input  logic [3:0]              i_RdIdx,
    output logic [127:0]            o_RoundKey,
    output logic                    o_fRdValid,
    output logic                    o_fBusy,
    output logic                    o_fDone,
    output logic                    o_fErr
);
    localparam int MAX_NK = MAX_KEY_BITS / 32;
    localparam int DEPTH  = 4 * (MAX_NK + 7);
    localparam int IW     = $clog2(DEPTH);

    // IDLE: wait for start | LOAD: seed w[0..Nk-1] | EXPAND: one word per cycle | DONE: publish, pulse done
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]              r_State;
    logic [1:0]              r_Mode;
    logic [MAX_KEY_BITS-1:0] r_Key;
    logic [31:0]             r_W [DEPTH];
    logic [IW-1:0]           r_Idx;
    logic [2:0]              r_Mod;
    logic [7:0]              r_Rcon;
    logic                    r_Valid;
    logic                    r_Done;
    logic                    r_Err;

    logic [3:0]    w_Nk;
    logic [2:0]    w_NkM1;
    logic [3:0]    w_Nr;
    logic [IW-1:0] w_Last;
    logic [IW-1:0] w_ChainBase;
    logic [IW-1:0] w_Back;
    logic [IW-1:0] w_RdBase;
    logic          w_ModeOk;
    logic          w_ChainErr;
    logic          w_UseChain;
    logic [31:0]   w_Prev;
    logic [31:0]   w_SubIn;
    logic [31:0]   w_SubOut;
    logic [31:0]   w_Temp;
    logic [31:0]   w_New;
    logic [7:0]    w_RconNext;
    logic          w_RdOk;

    always_comb begin
        w_Nk   = 4'd4;
        w_Nr   = 4'd10;
        w_Last = IW'(43);
        case (r_Mode)
            2'b01: begin w_Nk = 4'd6; w_Nr = 4'd12; w_Last = IW'(51); end
            2'b10: begin w_Nk = 4'd8; w_Nr = 4'd14; w_Last = IW'(59); end
            default: ;
        endcase
    end

    always_comb begin
        w_ModeOk = 1'b0;
        case (i_Mode)
            2'b00:   w_ModeOk = (MAX_KEY_BITS >= 128);
            2'b01:   w_ModeOk = (MAX_KEY_BITS >= 192);
            2'b10:   w_ModeOk = (MAX_KEY_BITS >= 256);
            default: w_ModeOk = 1'b0;
        endcase
    end

`ifdef KEYEXP_CHAIN_EN
    logic r_Chain;
    assign w_ChainErr = !i_fIsFirst && (!r_Valid || (i_Mode != r_Mode));
    assign w_UseChain = r_Chain;
`else
    assign w_ChainErr = 1'b0;
    assign w_UseChain = 1'b0;
`endif

    assign w_NkM1      = 3'(w_Nk - 4'd1);
    assign w_ChainBase = w_Last + IW'(1) - IW'(w_Nk);
    assign w_Back      = r_Idx - IW'(w_Nk);
    assign w_Prev      = r_W[r_Idx - IW'(1)];
    assign w_SubIn     = (r_Mod == 3'd0) ? {w_Prev[23:0], w_Prev[31:24]} : w_Prev;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        key_expansion_sbox u_sbox (
            .i_In  (w_SubIn[8*b +: 8]),
            .o_Out (w_SubOut[8*b +: 8])
        );
    end

    always_comb begin
        w_Temp = w_Prev;
        if (r_Mod == 3'd0)
            w_Temp = w_SubOut ^ {r_Rcon, 24'h0};
        else if (w_Nk == 4'd8 && r_Mod == 3'd4)
            w_Temp = w_SubOut;
    end

    assign w_New      = r_W[w_Back] ^ w_Temp;
    assign w_RconNext = {r_Rcon[6:0], 1'b0} ^ (r_Rcon[7] ? 8'h1b : 8'h00);

    // Store has no reset: its contents only matter once r_Valid is set.
    always_ff @(posedge i_Clk) begin
        if (r_State == S_LOAD) begin
            for (int j = 0; j < MAX_NK; j++) begin
                if (j < int'(w_Nk))
                    r_W[IW'(j)] <= w_UseChain ? r_W[w_ChainBase + IW'(j)]
                                              : r_Key[MAX_KEY_BITS-1-32*j -: 32];
            end
        end else if (r_State == S_EXPAND) begin
            r_W[r_Idx] <= w_New;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst) begin
            r_State <= S_IDLE;
            r_Mode  <= 2'b00;
            r_Key   <= '0;
            r_Idx   <= '0;
            r_Mod   <= 3'd0;
            r_Rcon  <= 8'h00;
            r_Valid <= 1'b0;
            r_Done  <= 1'b0;
            r_Err   <= 1'b0;
`ifdef KEYEXP_CHAIN_EN
            r_Chain <= 1'b0;
`endif
        end else begin
            r_Done <= 1'b0;
            r_Err  <= 1'b0;
            case (r_State)
                S_IDLE: begin
                    if (i_fStart) begin
                        if (w_ModeOk && !w_ChainErr) begin
                            r_Mode  <= i_Mode;
                            r_Key   <= i_Key;
                            r_Valid <= 1'b0;
                            r_State <= S_LOAD;
`ifdef KEYEXP_CHAIN_EN
                            r_Chain <= !i_fIsFirst;
`endif
                        end else begin
                            r_Err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_Idx   <= IW'(w_Nk);
                    r_Mod   <= 3'd0;
                    r_Rcon  <= 8'h01;
                    r_State <= S_EXPAND;
                end
                S_EXPAND: begin
                    r_Idx <= r_Idx + IW'(1);
                    r_Mod <= (r_Mod == w_NkM1) ? 3'd0 : r_Mod + 3'd1;
                    if (r_Mod == 3'd0)
                        r_Rcon <= w_RconNext;
                    if (r_Idx == w_Last)
                        r_State <= S_DONE;
                end
                default: begin
                    r_Done  <= 1'b1;
                    r_Valid <= 1'b1;
                    r_State <= S_IDLE;
                end
            endcase
        end
    end

    assign w_RdBase   = IW'({i_RdIdx, 2'b00});
    assign w_RdOk     = r_Valid && (i_RdIdx <= w_Nr);
    assign o_fRdValid = w_RdOk;
    assign o_RoundKey = w_RdOk ? {r_W[w_RdBase], r_W[w_RdBase + IW'(1)],
                                  r_W[w_RdBase + IW'(2)], r_W[w_RdBase + IW'(3)]} : 128'h0;
    assign o_fBusy    = (r_State == S_LOAD) || (r_State == S_EXPAND);
    assign o_fDone    = r_Done;
    assign o_fErr     = r_Err;
endmodule

// File: doc/key_expansion_multi.md
Name: key_expansion_multi

Overview:
Parametrised AES key-schedule engine supporting 128/192/256-bit keys, selected per start.
- Expands the cipher key one 32-bit word per cycle into an internal word store of up to 60 words.
- Exposes each 128-bit round key through an indexed read port.
- Sits between the key register and the round datapath and feeds round keys to the encrypt/decrypt cores.

Parameters:
MAX_KEY_BITS, 256, largest supported key size (128, 192 or 256); sets i_Key width and word-store depth (44/52/60 words).

Ports:
i_Clk  in  1  clock
i_Rst  in  1  reset, synchronous, active-low
i_Key  in  MAX_KEY_BITS  cipher key, MSB-first; for shorter modes the key occupies the top bits, lower bits ignored
i_Mode  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved
i_fStart  in  1  start request, sampled in IDLE only
i_RdIdx  in  4  round-key index r
o_RoundKey  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}
o_fRdValid  out  1  o_RoundKey is valid
o_fBusy  out  1  expansion in progress
o_fDone  out  1  one-cycle completion pulse
o_fErr  out  1  one-cycle rejection pulse

Behaviour:
- Reset (i_Rst=0 at clock edge): state=IDLE, all outputs 0, stored-valid flag cleared. Reset mid-expansion aborts the run; word-store contents are don't-care.
- Mode constants:
  - Nk=4/6/8, Nr=10/12/14.
  - Total words T=4*(Nr+1)=44/52/60.
- FSM states: IDLE -> LOAD -> EXPAND -> DONE -> IDLE.
- IDLE:
  - i_fStart=1 with a legal mode: latch mode and key, clear stored-valid, go to LOAD.
  - Illegal mode (11, or key size > MAX_KEY_BITS): o_fErr=1 for one cycle, stay IDLE, keep previous stored-valid.
- LOAD: one cycle; write w[0..Nk-1] from the key (w[0] = top 32 bits); word counter i=Nk; Rcon=0x01.
- EXPAND: one word per cycle.
  - temp = w[i-1].
  - If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}; after use, Rcon = xtime(Rcon) (0x80 -> 0x1B).
  - Else if Nk==8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-Nk] ^ temp.
  - i mod Nk is kept as a wrapping counter; no divider.
  - Leave EXPAND after writing w[T-1].
- DONE: one cycle; o_fDone=1; set stored-valid; return to IDLE.
- o_fBusy=1 in LOAD and EXPAND only.
- Latency, from the edge sampling i_fStart to o_fDone high: 42 / 48 / 54 cycles for 128 / 192 / 256.
- i_fStart while not IDLE: ignored, no error.
- Read port: combinational from the store.
  - o_fRdValid=1 iff stored-valid=1 and i_RdIdx <= Nr of the latched mode.
  - Otherwise o_fRdValid=0 and o_RoundKey=0.
  - During a run, o_fRdValid=0.
- SubWord: four byte S-box lookups through the team's shared S-box module, combinational within the cycle.

Optional Feature:
Macro KEYEXP_CHAIN_EN.
- Enabled:
  - Extra input i_fIsFirst (1 bit).
  - A start with i_fIsFirst=0 loads w[0..Nk-1] from the last Nk words of the previous completed expansion (same mode required) instead of i_Key.
  - i_fIsFirst=0 with stored-valid=0 or a mode change: o_fErr pulse, stay IDLE.
- Disabled: port absent; every start loads i_Key.

Test Plan:
- AES-128, key 2b7e1516 28aed2a6 abf71588 09cf4f3c:
  - o_fDone 42 cycles after start.
  - RdIdx=0 -> the key itself.
  - RdIdx=10 -> d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - RdIdx=11 -> o_fRdValid=0, o_RoundKey=0.
- AES-192, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - o_fDone at 48 cycles.
  - RdIdx=12 -> e98ba06f 448c773c 8ecc7204 01002202.
- AES-256, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - o_fDone at 54 cycles.
  - RdIdx=14 -> fe4890d1 e6188d0b 046df344 706c631e.
- Illegal mode and busy start:
  - i_Mode=11 with start -> o_fErr pulse, o_fBusy stays 0.
  - Start pulsed again mid-run -> ignored; done timing and keys unchanged.
- Reset mid-op: i_Rst=0 during the 20th EXPAND cycle.
  - Next cycle: IDLE, all outputs 0, o_fRdValid=0.
  - A fresh AES-128 run then gives correct keys.
- KEYEXP_CHAIN_EN: AES-128 run, then start with i_fIsFirst=0.
  - New round 0 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - Without a prior run -> o_fErr.
